// File: rtl/ifu_if.sv
// Fetch bundle: imem request/ack channel, execute redirect, decode stream.
// Latency: none, wires only.
// Backpressure: instr_ready from decode, imem_ack from memory.
interface ifu_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [29:0]     instr_out;
  logic [XLEN-1:0] instr_pc;
  logic            instr_illegal;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, instr_illegal,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, instr_illegal,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch: PC owner, single-outstanding imem fetch, 2-entry instr FIFO.
// Latency: imem_ack at edge N gives instr_valid after edge N; 1 instr/cycle peak.
// Backpressure: instr_ready low holds the head; fetch stops issuing once the FIFO would fill.
module ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [29:0]     word;
    logic            illegal;
  } entry_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_aligned;
  entry_t          fifo_mem [2];
  entry_t          head;
  entry_t          new_entry;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      occ_after_pop;
  logic            pop;
  logic            push;
  logic            issue;
  logic            unused_redirect_lsbs;

  // Head consumption and the occupancy that this cycle's issue decision sees.
  always_comb begin
    pop              = (count != 2'd0) && bus.instr_ready;
    occ_after_pop    = count - {1'b0, pop};
    pc_inc           = fetch_pc + XLEN'(4);
    redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
    unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    new_entry.pc      = fetch_pc;
    new_entry.word    = bus.imem_rdata[31:2];
    new_entry.illegal = (bus.imem_rdata[1:0] != 2'b11);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a redirect always wins over a same-cycle ack; issue only with room after the pop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!bus.redirect && (occ_after_pop < 2'd2)) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect && bus.imem_ack) begin
          state_nxt = ST_IDLE;
        end else if (bus.redirect) begin
          state_nxt = ST_DISCARD;
        end else if (bus.imem_ack) begin
          // After the push the FIFO holds occ_after_pop+1; keep fetching only if that is below 2.
          state_nxt = (occ_after_pop == 2'd0) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (bus.imem_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: memory port from state/registered address, decode port from the FIFO head.
  always_comb begin
    push  = (state == ST_WAIT) && bus.imem_ack && !bus.redirect;
    issue = (state_nxt == ST_WAIT) && ((state == ST_IDLE) || push);
    head  = fifo_mem[rd_ptr];
    bus.imem_req      = (state != ST_IDLE);
    bus.imem_addr     = req_addr;
    bus.instr_valid   = (count != 2'd0);
    bus.instr_out     = head.word;
    bus.instr_pc      = head.pc;
    bus.instr_illegal = head.illegal;
  end

  // Fetch PC tracks the next word to fetch; req_addr is frozen while a request is outstanding,
  // so a redirect during WAIT moves fetch_pc without disturbing the address on the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (bus.redirect) begin
        fetch_pc <= redirect_aligned;
      end else if (push) begin
        fetch_pc <= pc_inc;
      end
      if (issue) begin
        req_addr <= push ? pc_inc : fetch_pc;
      end
    end
  end

  // Two-entry FIFO; a redirect flushes it, which also drops any same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '{pc: RESET_PC, word: '0, illegal: 1'b0};
      end
    end else if (bus.redirect) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= new_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios with literal expectations plus a random phase,
// all watched by a queue-based model of the fetch stream.
module tb_ifu;
  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n;

  ifu_if #(.XLEN(XLEN)) bus ();

  ifu #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat;
  int          mem_cnt;
  int          cur_lat;
  bit          mem_rand;
  bit          spur;
  logic [31:0] ill_addr;

  task automatic mem_drive();
    logic [1:0] lb;
    if (bus.imem_req) begin
      if (mem_cnt >= cur_lat) begin
        bus.imem_ack = 1'b1;
        mem_cnt = 0;
        cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        bus.imem_ack = 1'b0;
        mem_cnt++;
      end
    end else begin
      bus.imem_ack = spur && ($urandom_range(0, 9) == 0);
      mem_cnt = 0;
      cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
    end
    lb = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    if (bus.imem_addr == ill_addr)
      bus.imem_rdata = 32'h0000_0001;
    else if (mem_rand)
      bus.imem_rdata = {bus.imem_addr[31:2] ^ 30'h15A53C3C, lb};
    else
      bus.imem_rdata = 32'h0000_0013;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    mem_drive();
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q_pc[$];
  logic [31:0] q_dat[$];
  logic [31:0] exp_pc;
  logic [31:0] out_addr;
  logic [31:0] head_dat;
  bit          m_on    = 1'b0;
  bit          in_req  = 1'b0;
  bit          stale   = 1'b0;
  bit          pop_now;
  int          idle_cnt = 0;
  int          pops     = 0;

  always @(negedge clk) begin
    if (m_on) begin
      chk_b("m_valid", bus.instr_valid, q_pc.size() != 0);
      if (q_pc.size() != 0) begin
        head_dat = q_dat[0];
        chk_w("m_pc", bus.instr_pc, q_pc[0]);
        chk_w("m_out", {2'b00, bus.instr_out}, {2'b00, head_dat[31:2]});
        chk_b("m_illegal", bus.instr_illegal, head_dat[1:0] != 2'b11);
      end
      if (in_req) begin
        chk_b("m_req_held", bus.imem_req, 1'b1);
        chk_w("m_addr_stable", bus.imem_addr, out_addr);
      end else if (bus.imem_req) begin
        chk_w("m_req_addr", bus.imem_addr, exp_pc);
      end
      if (!bus.imem_req && q_pc.size() == 0 && !bus.redirect && rst_n) idle_cnt++;
      else idle_cnt = 0;
      chk_b("m_idle_stall", idle_cnt > 2, 1'b0);
    end

    if (!rst_n) begin
      q_pc.delete();
      q_dat.delete();
      in_req   = 1'b0;
      stale    = 1'b0;
      exp_pc   = RST_PC;
      idle_cnt = 0;
      m_on     = 1'b1;
    end else if (m_on) begin
      pop_now = (q_pc.size() != 0) && bus.instr_ready;
      if (pop_now) begin
        void'(q_pc.pop_front());
        void'(q_dat.pop_front());
        pops++;
      end
      if (bus.imem_req) begin
        if (!in_req) out_addr = exp_pc;
        if (bus.imem_ack) begin
          if (!stale && !bus.redirect) begin
            q_pc.push_back(out_addr);
            q_dat.push_back(bus.imem_rdata);
            exp_pc = out_addr + 32'd4;
          end
          in_req = 1'b0;
          stale  = 1'b0;
        end else begin
          in_req = 1'b1;
          if (bus.redirect) stale = 1'b1;
        end
      end
      if (bus.redirect) begin
        q_pc.delete();
        q_dat.delete();
        exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end
      chk_b("m_fifo_overflow", q_pc.size() <= 2, 1'b1);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_reset(input logic rdy);
    tick();
    rst_n = 1'b0;
    bus.instr_ready = rdy;
    tick();
    tick();
    look();
    chk_b("rst_req", bus.imem_req, 1'b0);
    chk_b("rst_valid", bus.instr_valid, 1'b0);
    chk_b("rst_illegal", bus.instr_illegal, 1'b0);
    chk_w("rst_addr", bus.imem_addr, RST_PC);
    chk_w("rst_pc", bus.instr_pc, RST_PC);
    chk_w("rst_out", {2'b00, bus.instr_out}, 32'h0);
    tick();
    rst_n = 1'b1;
  endtask

  bit found;
  int p0;

  initial begin
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b1;
    mem_lat = 0; mem_cnt = 0; cur_lat = 0;
    mem_rand = 1'b0; spur = 1'b0;
    ill_addr = 32'h2;

    // Streaming NOPs with ready high: one instruction per cycle.
    do_reset(1'b1);
    tick(); look();
    chk_b("t1_first_req", bus.imem_req, 1'b1);
    chk_w("t1_first_addr", bus.imem_addr, 32'h0);
    chk_b("t1_not_yet_valid", bus.instr_valid, 1'b0);
    tick(); look();
    chk_b("t1_valid", bus.instr_valid, 1'b1);
    chk_w("t1_pc0", bus.instr_pc, 32'h0);
    chk_w("t1_out", {2'b00, bus.instr_out}, 32'h4);
    chk_w("t1_addr4", bus.imem_addr, 32'h4);
    tick(); look();
    chk_w("t1_pc4", bus.instr_pc, 32'h4);
    chk_w("t1_addr8", bus.imem_addr, 32'h8);
    tick(); look();
    chk_w("t1_pc8", bus.instr_pc, 32'h8);
    chk_w("t1_addr12", bus.imem_addr, 32'hC);

    // Decode stalled: FIFO fills, requests stop, head holds.
    do_reset(1'b0);
    tick(); look();
    chk_b("t2_req0", bus.imem_req, 1'b1);
    tick(); look();
    chk_w("t2_head_a", bus.instr_pc, 32'h0);
    chk_w("t2_addr4", bus.imem_addr, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick(); look();
      chk_b("t2_req_off", bus.imem_req, 1'b0);
      chk_b("t2_valid_hold", bus.instr_valid, 1'b1);
      chk_w("t2_head_hold", bus.instr_pc, 32'h0);
    end
    tick();
    bus.instr_ready = 1'b1;
    look();
    chk_w("t2_rel_pc0", bus.instr_pc, 32'h0);
    tick(); look();
    chk_w("t2_rel_pc4", bus.instr_pc, 32'h4);
    chk_b("t2_rel_req", bus.imem_req, 1'b1);
    chk_w("t2_rel_addr8", bus.imem_addr, 32'h8);
    tick(); look();
    chk_w("t2_rel_pc8", bus.instr_pc, 32'h8);

    // Slow memory, redirect while waiting: stale word dropped.
    mem_lat = 3;
    do_reset(1'b1);
    tick(); look();
    chk_b("t3_req", bus.imem_req, 1'b1);
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    look();
    tick(); look();
    chk_b("t3_discard_req", bus.imem_req, 1'b1);
    chk_w("t3_discard_addr", bus.imem_addr, 32'h0);
    chk_b("t3_discard_valid", bus.instr_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); look();
      if (bus.instr_valid) found = 1'b1;
    end
    chk_b("t3_found", found, 1'b1);
    chk_w("t3_pc", bus.instr_pc, 32'h100);
    chk_w("t3_out", {2'b00, bus.instr_out}, 32'h4);

    // Redirect coinciding with ack while the FIFO holds one entry.
    mem_lat = 0;
    do_reset(1'b0);
    tick();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    look();
    chk_w("t4_pre_pc", bus.instr_pc, 32'h0);
    tick(); look();
    chk_b("t4_flushed", bus.instr_valid, 1'b0);
    chk_b("t4_idle", bus.imem_req, 1'b0);
    tick(); look();
    chk_b("t4_req", bus.imem_req, 1'b1);
    chk_w("t4_addr", bus.imem_addr, 32'h200);

    // Compressed-looking word flagged illegal, neighbour is clean.
    bus.instr_ready = 1'b1;
    ill_addr = 32'h208;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); look();
      if (bus.instr_valid && bus.instr_pc == 32'h208) found = 1'b1;
    end
    chk_b("t5_found", found, 1'b1);
    chk_b("t5_illegal", bus.instr_illegal, 1'b1);
    chk_w("t5_out", {2'b00, bus.instr_out}, 32'h0);
    tick(); look();
    chk_w("t5_next_pc", bus.instr_pc, 32'h20C);
    chk_b("t5_next_legal", bus.instr_illegal, 1'b0);
    chk_w("t5_next_out", {2'b00, bus.instr_out}, 32'h4);

    // PC wrap at the top of the address space; low redirect bits ignored.
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    ill_addr = 32'h2;
    look();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); look();
      if (bus.instr_valid) found = 1'b1;
    end
    chk_b("t6_found", found, 1'b1);
    chk_w("t6_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
    tick(); look();
    chk_b("t6_wrap_valid", bus.instr_valid, 1'b1);
    chk_w("t6_pc_wrap", bus.instr_pc, 32'h0);

    // Reset while a request is outstanding.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.imem_req && !bus.imem_ack) begin
        rst_n = 1'b0;
        found = 1'b1;
      end
    end
    chk_b("t7_found", found, 1'b1);
    tick();
    rst_n = 1'b1;
    look();
    chk_b("t7_req_off", bus.imem_req, 1'b0);
    chk_b("t7_valid_off", bus.instr_valid, 1'b0);
    tick(); look();
    chk_b("t7_restart_req", bus.imem_req, 1'b1);
    chk_w("t7_restart_addr", bus.imem_addr, RST_PC);

    // Random traffic under the model.
    mem_rand = 1'b1;
    spur = 1'b1;
    mem_lat = 0;
    do_reset(1'b1);
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                      : $urandom;
      end
      rst_n = ($urandom_range(0, 249) != 0);
    end
    look();
    chk_b("rand_progress", (pops - p0) > 200, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
